rv_alu_decode: RTL and testbench
================================

# rv_alu_decode

Decode-and-issue stage that sits directly upstream of the 32-bit ALU. It accepts a RISC-V RV32I instruction word plus the register-file read values, decodes the integer ALU instructions, and produces the ALU's 3-bit operation code, both operands, and the writeback target. A valid/ready pipeline register sits on both sides. Unsupported encodings are consumed, dropped, and counted.

## Interface
- `CNT_W`, default 16: width of the illegal-instruction counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: instruction word and operand values are valid.
- `in_ready` output 1: stage can accept an instruction this cycle.
- `in_instr` input 32: RV32I instruction word.
- `in_rs1_val` input 32: register value selected by `instr[19:15]`.
- `in_rs2_val` input 32: register value selected by `instr[24:20]`.
- `out_valid` output 1: issued operation is valid.
- `out_ready` input 1: ALU/writeback side accepts the operation.
- `out_sel` output 3: ALU code. ADD=000, SHL=001, SUB=010, XOR=100, SHR=101, OR=110, AND=111.
- `out_op1` output 32: ALU operand 1.
- `out_op2` output 32: ALU operand 2.
- `out_rd` output 5: destination register.
- `out_we` output 1: write enable. It is 0 when rd=0.
- `illegal_pulse` output 1: one-cycle pulse when an illegal instruction is dropped.
- `illegal_cnt` output CNT_W: saturating count of dropped instructions.

## Operation
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- Opcode 0110011 (OP):
  - funct7=0000000 with funct3 000/001/100/101/110/111 maps to ADD/SHL/XOR/SHR/OR/AND.
  - funct7=0100000 with funct3=000 maps to SUB (010).
  - `op1` = rs1_val. `op2` = rs2_val.
- Opcode 0010011 (OP-IMM):
  - funct3 000/100/110/111 map to ADD/XOR/OR/AND, with `op2` = sign-extended imm[11:0].
  - funct3 001 (funct7=0000000) maps to SHL, and funct3 101 (funct7=0000000) maps to SHR, with `op2` = {27'b0, instr[24:20]}.
- Opcode 0110111 (LUI): sel=ADD, `op1`=0, `op2`={instr[31:12],12'b0}.
- Shift masking: for R-type SHL/SHR, `op2` = {27'b0, rs2_val[4:0]}. The ALU shifts by its full operand, so the decoder masks.
- Every other encoding is illegal. This covers SLT/SLTU/SRA/SRAI, bad funct7, and other opcodes. Handling:
  - The instruction is accepted and not issued; `out_valid` is unaffected.
  - `illegal_pulse`=1 in the following cycle.
  - `illegal_cnt` increments and saturates at all-ones.
- Order is strictly preserved. No instruction is duplicated or lost under backpressure.

## Timing
- Reset values: `out_valid`=0; `out_sel`, `out_op1`, `out_op2`, `out_rd`, `out_we`=0; `illegal_pulse`=0; `illegal_cnt`=0; `in_ready`=1.
- Latency: a legal instruction accepted at edge N presents `out_valid`=1 after edge N (registered output).
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Outputs are held stable while `out_valid && !out_ready`.
- Simultaneous accept and issue on a full stage: the new word replaces the issued one with no bubble.
- Illegal instruction accepted while the output is stalled: it is counted and the held output is unchanged.
- `rst_n` asserted mid-operation: in-flight entries are discarded immediately (asynchronous), outputs return to reset values, and the counter clears.

## Configuration
- Macro `RV_ALU_DEC_SKID_EN`.
- Defined: 2-entry skid buffer (main + skid register).
  - `in_ready` is a register output with no combinational path from `out_ready`.
  - `in_ready` deasserts only when both entries are occupied.
  - The skid entry drains first, preserving order.
- Undefined: single output register.
  - `in_ready` = `!out_valid || out_ready` (combinational).
- Both builds have identical latency and ordering.

## Test plan
- ADDI: `in_instr`=0xFFF08293, rs1_val=0x00000010 -> next cycle sel=000, op1=0x00000010, op2=0xFFFFFFFF, rd=5, we=1.
- SUB: `in_instr`=0x402081B3, rs1_val=7, rs2_val=9 -> sel=010, op1=7, op2=9, rd=3. SLL with rs2_val=0x00000023 -> sel=001, op2=0x00000003.
- Illegal: SLT 0x0020A1B3 -> no `out_valid`, `illegal_pulse` for 1 cycle, `illegal_cnt`=1. Repeat 2^CNT_W+3 times -> count holds at all-ones.
- Backpressure: stream 8 legal ADDIs (rd=1..8) with `out_ready` low for cycles 2–6 -> all 8 issued in rd order, none duplicated. With the macro defined, `in_ready` never depends combinationally on `out_ready`.
- rd=0: ADDI x0,x0,5 (0x00500013) -> issued with we=0, op2=5.
- Reset: drop `rst_n` while `out_valid`=1 and stalled -> `out_valid` goes 0 asynchronously. After release, `in_ready`=1 and `illegal_cnt`=0.

Source files
------------

// File: rtl/rv_alu_decode.sv
// RV32I integer-ALU decode/issue stage with valid/ready handshakes on both sides.
// Define RV_ALU_DEC_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module rv_alu_decode #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_sel,
  output logic [31:0]      out_op1,
  output logic [31:0]      out_op2,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    SEL_ADD = 3'b000,
    SEL_SHL = 3'b001,
    SEL_SUB = 3'b010,
    SEL_XOR = 3'b100,
    SEL_SHR = 3'b101,
    SEL_OR  = 3'b110,
    SEL_AND = 3'b111
  } alu_sel_e;

  typedef struct packed {
    alu_sel_e    sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
  } issue_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  issue_t     dec;
  logic       dec_legal;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // funct3 values of the supported ops coincide with the ALU select codes.
  always_comb begin
    dec       = '0;
    dec_legal = 1'b0;
    dec.rd    = in_instr[11:7];
    dec.we    = |in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.op1 = in_rs1_val;
        dec.op2 = in_rs2_val;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000, 3'b100, 3'b110, 3'b111: begin
              dec.sel   = alu_sel_e'(funct3);
              dec_legal = 1'b1;
            end
            3'b001, 3'b101: begin
              dec.sel   = alu_sel_e'(funct3);
              dec.op2   = {27'b0, in_rs2_val[4:0]};
              dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.sel   = SEL_SUB;
          dec_legal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.op1 = in_rs1_val;
        dec.op2 = {{20{in_instr[31]}}, in_instr[31:20]};
        case (funct3)
          3'b000, 3'b100, 3'b110, 3'b111: begin
            dec.sel   = alu_sel_e'(funct3);
            dec_legal = 1'b1;
          end
          3'b001, 3'b101: begin
            dec.sel   = alu_sel_e'(funct3);
            dec.op2   = {27'b0, in_instr[24:20]};
            dec_legal = (funct7 == 7'b0000000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.sel   = SEL_ADD;
        dec.op1   = '0;
        dec.op2   = {in_instr[31:12], 12'b0};
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  issue_t           main_q, main_d;
  logic             main_valid_q, main_valid_d;
  logic             illegal_pulse_q, illegal_pulse_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             load, drop, pop;

  assign load = in_valid && in_ready && dec_legal;
  assign drop = in_valid && in_ready && !dec_legal;
  assign pop  = main_valid_q && out_ready;

`ifdef RV_ALU_DEC_SKID_EN
  issue_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // The skid entry always holds the younger word, so it refills main on a pop.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        if (load) begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end else if (load) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (load) begin
      if (!main_valid_q) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (load) begin
      main_d       = dec;
      main_valid_d = 1'b1;
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    illegal_pulse_d = drop;
    illegal_cnt_d   = illegal_cnt_q;
    if (drop && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q          <= '0;
      main_valid_q    <= 1'b0;
      illegal_pulse_q <= 1'b0;
      illegal_cnt_q   <= '0;
`ifdef RV_ALU_DEC_SKID_EN
      skid_q          <= '0;
      skid_valid_q    <= 1'b0;
      in_ready_q      <= 1'b1;
`endif
    end else begin
      main_q          <= main_d;
      main_valid_q    <= main_valid_d;
      illegal_pulse_q <= illegal_pulse_d;
      illegal_cnt_q   <= illegal_cnt_d;
`ifdef RV_ALU_DEC_SKID_EN
      skid_q          <= skid_d;
      skid_valid_q    <= skid_valid_d;
      in_ready_q      <= in_ready_d;
`endif
    end
  end

  assign out_valid     = main_valid_q;
  assign out_sel       = main_q.sel;
  assign out_op1       = main_q.op1;
  assign out_op2       = main_q.op2;
  assign out_rd        = main_q.rd;
  assign out_we        = main_q.we;
  assign illegal_pulse = illegal_pulse_q;
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_rv_alu_decode.sv
// Scoreboard bench for rv_alu_decode: the driver queues expected issues, a monitor pops on transfers.
module tb_rv_alu_decode;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_we, illegal_pulse;
  logic [31:0]   in_instr, in_rs1_val, in_rs2_val, out_op1, out_op2;
  logic [2:0]    out_sel;
  logic [4:0]    out_rd;
  logic [CW-1:0] illegal_cnt;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int stall_from = -1;
  int stall_to = -1;
  logic force_stall = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  bit ill_at[int];
  exp_t q[$];

  rv_alu_decode #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_we(out_we),
    .illegal_pulse(illegal_pulse), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = !(force_stall || (edge_cnt >= stall_from && edge_cnt < stall_to));
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pulse/counter model every cycle, hold check while stalled, pop on transfer.
  initial begin
    exp_t cur, prev, e;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      cur = '{out_sel, out_op1, out_op2, out_rd, out_we};
      chk("illegal_cnt", 80'(illegal_cnt), 80'(exp_cnt));
      chk("illegal_pulse", 80'(illegal_pulse), 80'(ill_at.exists(edge_cnt)));
      if (prev_stall) begin
        chk("hold_valid", 80'(out_valid), 80'(1));
        chk("hold_data", 80'(cur), 80'(prev));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got %0h expected none", cur);
        end else begin
          e = q.pop_front();
          chk("issue", 80'(cur), 80'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = cur;
    end
  end

  // Called at a falling edge; returns at a falling edge with in_valid low.
  task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic legal, input exp_t e);
    logic fired;
    fired = 1'b0;
    in_valid = 1'b1;
    in_instr = instr;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    for (int i = 0; i < 64 && !fired; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      fired = in_ready;
      if (fired && !legal) ill_at[edge_cnt + 1] = 1'b1;
      @(posedge clk);
      if (fired) begin
        if (legal) q.push_back(e);
        else if (exp_cnt != '1) exp_cnt++;
      end
    end
    if (!fired) chk("accept_timeout", 80'(0), 80'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic leg(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [2:0] sel, input logic [31:0] op1, input logic [31:0] op2,
                     input logic [4:0] rd, input logic we);
    send(instr, rs1, rs2, 1'b1, '{sel, op1, op2, rd, we});
  endtask

  task automatic ill(input logic [31:0] instr);
    send(instr, 32'h1111_1111, 32'h2222_2222, 1'b0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(negedge clk);
      #3;
    end
    chk("drain", 80'(q.size()), 80'(0));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs1_val = '0;
    in_rs2_val = '0;
    #1;
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_cnt", 80'(illegal_cnt), 80'(0));
    chk("rst_pulse", 80'(illegal_pulse), 80'(0));
    chk("rst_data", 80'({out_sel, out_op1, out_op2, out_rd, out_we}), 80'(0));
    #11 rst_n = 1'b1;
    @(negedge clk);

    leg(32'hFFF08293, 32'h0000_0010, 32'h0, 3'b000, 32'h0000_0010, 32'hFFFF_FFFF, 5'd5, 1'b1);
    leg(32'h402081B3, 32'd7, 32'd9, 3'b010, 32'd7, 32'd9, 5'd3, 1'b1);
    leg(32'h002091B3, 32'h55, 32'h23, 3'b001, 32'h55, 32'h3, 5'd3, 1'b1);
    leg(32'h0020C1B3, 32'hF0F0, 32'hFF, 3'b100, 32'hF0F0, 32'hFF, 5'd3, 1'b1);
    leg(32'h0020D1B3, 32'h8000_0000, 32'hFFFF_FFE5, 3'b101, 32'h8000_0000, 32'h5, 5'd3, 1'b1);
    leg(32'h0020E1B3, 32'h1, 32'h2, 3'b110, 32'h1, 32'h2, 5'd3, 1'b1);
    leg(32'h0020F1B3, 32'h3, 32'h4, 3'b111, 32'h3, 32'h4, 5'd3, 1'b1);
    leg(32'h002081B3, 32'h5, 32'h8000_0000, 3'b000, 32'h5, 32'h8000_0000, 5'd3, 1'b1);
    leg(32'h123452B7, 32'hDEAD, 32'hBEEF, 3'b000, 32'h0, 32'h1234_5000, 5'd5, 1'b1);
    leg(32'h01F09293, 32'h1, 32'h0, 3'b001, 32'h1, 32'd31, 5'd5, 1'b1);
    leg(32'h01F0D293, 32'h1, 32'h0, 3'b101, 32'h1, 32'd31, 5'd5, 1'b1);
    leg(32'h8000E293, 32'h9, 32'h0, 3'b110, 32'h9, 32'hFFFF_F800, 5'd5, 1'b1);
    leg(32'h7FF0C293, 32'h9, 32'h0, 3'b100, 32'h9, 32'h0000_07FF, 5'd5, 1'b1);
    leg(32'h0FF0F293, 32'h9, 32'h0, 3'b111, 32'h9, 32'h0000_00FF, 5'd5, 1'b1);
    leg(32'h00500013, 32'h0, 32'h0, 3'b000, 32'h0, 32'h5, 5'd0, 1'b0);
    drain();

    ill(32'h0020A1B3);
    repeat (2) @(negedge clk);
    chk("cnt_after_slt", 80'(illegal_cnt), 80'(1));
    leg(32'h402081B3, 32'd7, 32'd9, 3'b010, 32'd7, 32'd9, 5'd3, 1'b1);
    ill(32'h0020B1B3);
    ill(32'h4020D1B3);
    leg(32'h002091B3, 32'h55, 32'h23, 3'b001, 32'h55, 32'h3, 5'd3, 1'b1);
    ill(32'h020081B3);
    ill(32'h4020E1B3);
    ill(32'h41F0D293);
    ill(32'h0050A293);
    ill(32'h02009293);
    ill(32'h0000A283);
    ill(32'h00000000);
    drain();

    for (int n = 0; n < (1 << CW) + 3; n++) ill(32'h0020A1B3);
    repeat (2) @(negedge clk);
    chk("cnt_saturated", 80'(illegal_cnt), 80'(4'hF));

    stall_from = edge_cnt + 2;
    stall_to = edge_cnt + 7;
    for (int n = 1; n <= 8; n++) begin
      leg((32'(n) << 20) | (32'(n) << 7) | 32'h13, 32'(n * 16), 32'h0,
          3'b000, 32'(n * 16), 32'(n), 5'(n), 1'b1);
    end
    drain();

    force_stall = 1'b1;
    @(negedge clk);
    leg(32'hFFF08293, 32'h0000_0010, 32'h0, 3'b000, 32'h0000_0010, 32'hFFFF_FFFF, 5'd5, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("stalled_valid", 80'(out_valid && !out_ready), 80'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 80'(out_valid), 80'(0));
    chk("async_rst_data", 80'({out_sel, out_op1, out_op2, out_rd, out_we}), 80'(0));
    q.delete();
    ill_at.delete();
    exp_cnt = '0;
    force_stall = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 80'(in_ready), 80'(1));
    chk("post_rst_cnt", 80'(illegal_cnt), 80'(0));
    @(negedge clk);
    leg(32'h00500013, 32'h0, 32'h0, 3'b000, 32'h0, 32'h5, 5'd0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
